booth_product_accumulator: RTL and testbench



---
 rtl/mult_pkg.sv | 16 +
 rtl/booth_product_accumulator_acc_sat_add.sv | 33 +++
 rtl/booth_product_accumulator.sv | 105 ++++++++++
 tb/tb_booth_product_accumulator.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the Booth multiplier and its product accumulator.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int PROD_W_DEF = 64;
  localparam int ACC_W_DEF  = 64;

  localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/booth_product_accumulator_acc_sat_add.sv
// Combinational signed ACC_W adder with overflow detect; clamps on overflow
// when ACC_SATURATE_EN is defined, otherwise wraps.
module acc_sat_add #(
  parameter int ACC_W = 64
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  output logic signed [ACC_W-1:0] sum,
  output logic                    overflow
);

  logic signed [ACC_W-1:0] raw;

`ifdef ACC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

  function automatic logic signed [ACC_W-1:0] saturate(input logic neg);
    return neg ? MIN_V : MAX_V;
  endfunction
`endif

  always_comb begin
    raw      = a + b;
    overflow = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
    sum      = raw;
`ifdef ACC_SATURATE_EN
    // Both addends share a sign on overflow, so the clamp direction follows a.
    if (overflow) sum = saturate(a[ACC_W-1]);
`endif
  end

endmodule

// File: rtl/booth_product_accumulator.sv
// Batch accumulator behind the Booth multiplier: sums len products, holds the
// result on a valid/ready port. Optional ACC_SATURATE_EN clamps instead of wrapping.
module booth_product_accumulator
  import mult_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     clear,
  input  logic [LEN_W-1:0]         len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_product,
  input  logic                     in_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_acc,
  output logic                     out_overflow,
  output logic [LEN_W-1:0]         out_count
);

  state_t                  state_p1;
  logic signed [ACC_W-1:0] acc_p1;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    add_ovf;
  logic                    accept;
  logic                    vld_p1;
  logic                    ovf_p1;
  logic [LEN_W-1:0]        count_p1;
  logic [LEN_W-1:0]        len_p1;
  logic [LEN_W-1:0]        len_eff;
  logic [LEN_W-1:0]        count_inc;

  assign prod_ext  = ACC_W'(in_product);
  assign len_eff   = (len == '0) ? LEN_W'(1) : len;
  assign count_inc = count_p1 + LEN_W'(1);

  acc_sat_add #(
    .ACC_W(ACC_W)
  ) u_add (
    .a       (acc_p1),
    .b       (prod_ext),
    .sum     (sum),
    .overflow(add_ovf)
  );

  // A held result frees the slot in the same cycle it is taken, so a new
  // batch can start with no bubble; clear blocks acceptance outright.
  assign in_ready = en & ~reset & ~clear & ((state_p1 != HOLD) | out_ready);
  assign accept   = in_valid & in_ready;

  // Stage p1: batch state, running sum, count and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1 <= IDLE;
      vld_p1   <= 1'b0;
      acc_p1   <= '0;
      count_p1 <= '0;
      ovf_p1   <= 1'b0;
      len_p1   <= '0;
    end else if (en) begin
      if (clear) begin
        state_p1 <= IDLE;
        vld_p1   <= 1'b0;
        acc_p1   <= '0;
        count_p1 <= '0;
        ovf_p1   <= 1'b0;
      end else if (accept && state_p1 != ACCUM) begin
        len_p1   <= len_eff;
        acc_p1   <= prod_ext;
        count_p1 <= LEN_W'(1);
        ovf_p1   <= in_overflow;
        if (len_eff == LEN_W'(1)) begin
          state_p1 <= HOLD;
          vld_p1   <= 1'b1;
        end else begin
          state_p1 <= ACCUM;
          vld_p1   <= 1'b0;
        end
      end else if (accept) begin
        acc_p1   <= sum;
        count_p1 <= count_inc;
        ovf_p1   <= ovf_p1 | in_overflow | add_ovf;
        if (count_inc == len_p1) begin
          state_p1 <= HOLD;
          vld_p1   <= 1'b1;
        end
      end else if (state_p1 == HOLD && out_ready) begin
        state_p1 <= IDLE;
        vld_p1   <= 1'b0;
      end
    end
  end

  assign out_valid    = vld_p1;
  assign out_acc      = acc_p1;
  assign out_overflow = ovf_p1;
  assign out_count    = count_p1;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Self-checking bench for booth_product_accumulator: directed batch table,
// multi-cycle corner sequences, then randomized traffic against a batch model.
module tb_booth_product_accumulator;

  localparam int PROD_W = 64;
  localparam int ACC_W  = 64;
  localparam int LEN_W  = 8;

  localparam logic signed [63:0] MAXV = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [63:0] MINV = 64'sh8000_0000_0000_0000;
  localparam logic signed [63:0] P62  = 64'sh4000_0000_0000_0000;
  localparam logic signed [65:0] AMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] AMIN = 66'sh3_8000_0000_0000_0000;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     en;
  logic                     clear;
  logic [LEN_W-1:0]         len;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] in_product;
  logic                     in_overflow;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_acc;
  logic                     out_overflow;
  logic [LEN_W-1:0]         out_count;

  int checks = 0;
  int errors = 0;

  booth_product_accumulator #(
    .PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
    .in_overflow(in_overflow), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_overflow(out_overflow), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic feed(input logic [7:0] l, input logic signed [63:0] p, input logic f);
    in_valid = 1'b1; len = l; in_product = p; in_overflow = f;
    @(negedge clk);
    in_valid = 1'b0; in_overflow = 1'b0;
  endtask

  typedef struct {
    logic [7:0]             len;
    int                     n;
    logic [7:0][63:0]       p;
    logic [7:0]             ovf_mask;
    logic signed [63:0]     exp_acc;
    logic                   exp_ovf;
    logic [7:0]             exp_cnt;
  } vec_t;

  vec_t vecs[6];

  // Batch-level reference: exact wide sum, then wrap or clamp on range exit.
  logic               m_hold, m_active, m_ovf;
  logic [7:0]         m_len, m_cnt;
  logic signed [63:0] m_acc;

  task automatic model_add(input logic signed [63:0] p, input logic f);
    logic signed [65:0] ex;
    ex = m_acc + p;
    m_ovf = m_ovf | f;
    if (ex > AMAX || ex < AMIN) begin
      m_ovf = 1'b1;
`ifdef ACC_SATURATE_EN
      m_acc = (ex > AMAX) ? MAXV : MINV;
`else
      m_acc = ex[63:0];
`endif
    end else begin
      m_acc = ex[63:0];
    end
    m_cnt = m_cnt + 8'd1;
  endtask

  initial begin
    for (int v = 0; v < 6; v++) begin
      vecs[v].p = '0; vecs[v].ovf_mask = '0;
    end
    vecs[0].len = 8; vecs[0].n = 8;
    vecs[0].p[0] = -64'sd35; vecs[0].p[1] = 64'sd6;  vecs[0].p[2] = 64'sd48;
    vecs[0].p[3] = -64'sd45; vecs[0].p[4] = 64'sd0;  vecs[0].p[5] = 64'sd10;
    vecs[0].p[6] = 64'sd24;  vecs[0].p[7] = 64'sd7;
    vecs[0].exp_acc = 64'sd15; vecs[0].exp_ovf = 1'b0; vecs[0].exp_cnt = 8;

    vecs[1].len = 2; vecs[1].n = 2; vecs[1].p[0] = P62; vecs[1].p[1] = P62;
`ifdef ACC_SATURATE_EN
    vecs[1].exp_acc = MAXV;
`else
    vecs[1].exp_acc = MINV;
`endif
    vecs[1].exp_ovf = 1'b1; vecs[1].exp_cnt = 2;

    vecs[2].len = 3; vecs[2].n = 3;
    vecs[2].p[0] = 64'sd10; vecs[2].p[1] = -64'sd3; vecs[2].p[2] = 64'sd4;
    vecs[2].ovf_mask = 8'b0000_0010;
    vecs[2].exp_acc = 64'sd11; vecs[2].exp_ovf = 1'b1; vecs[2].exp_cnt = 3;

    vecs[3].len = 0; vecs[3].n = 1; vecs[3].p[0] = 64'sd9;
    vecs[3].exp_acc = 64'sd9; vecs[3].exp_ovf = 1'b0; vecs[3].exp_cnt = 1;

    vecs[4].len = 2; vecs[4].n = 2; vecs[4].p[0] = MINV; vecs[4].p[1] = -64'sd1;
`ifdef ACC_SATURATE_EN
    vecs[4].exp_acc = MINV;
`else
    vecs[4].exp_acc = MAXV;
`endif
    vecs[4].exp_ovf = 1'b1; vecs[4].exp_cnt = 2;

    vecs[5].len = 3; vecs[5].n = 3;
    vecs[5].p[0] = P62; vecs[5].p[1] = P62; vecs[5].p[2] = -64'sd1;
`ifdef ACC_SATURATE_EN
    vecs[5].exp_acc = 64'sh7FFF_FFFF_FFFF_FFFE;
`else
    vecs[5].exp_acc = MAXV;
`endif
    vecs[5].exp_ovf = 1'b1; vecs[5].exp_cnt = 3;

    reset = 1'b1; en = 1'b1; clear = 1'b0; len = '0; in_valid = 1'b0;
    in_product = '0; in_overflow = 1'b0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst out_acc", out_acc, 64'd0);
    chk("rst out_overflow", 64'(out_overflow), 64'd0);
    chk("rst out_count", 64'(out_count), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table of back-to-back batches with the consumer always ready
    out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        if (i > 0) chk($sformatf("v%0d busy", v), 64'(out_valid), 64'd0);
        in_valid = 1'b1; len = vecs[v].len;
        in_product = vecs[v].p[i]; in_overflow = vecs[v].ovf_mask[i];
        #1 chk($sformatf("v%0d in_ready", v), 64'(in_ready), 64'd1);
        @(negedge clk);
      end
      in_valid = 1'b0; in_overflow = 1'b0;
      chk($sformatf("v%0d out_valid", v), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d out_acc", v), out_acc, vecs[v].exp_acc);
      chk($sformatf("v%0d out_count", v), 64'(out_count), 64'(vecs[v].exp_cnt));
      chk($sformatf("v%0d out_overflow", v), 64'(out_overflow), 64'(vecs[v].exp_ovf));
    end
    @(negedge clk);
    chk("drain out_valid", 64'(out_valid), 64'd0);

    // Held result under back-pressure, then handoff with a same-cycle new batch
    out_ready = 1'b0;
    feed(8'd1, -64'sd35, 1'b0);
    in_valid = 1'b1; len = 8'd1; in_product = 64'sd6;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("hold out_valid", 64'(out_valid), 64'd1);
      chk("hold out_acc", out_acc, -64'sd35);
      chk("hold in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("handoff in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b out_valid", 64'(out_valid), 64'd1);
    chk("b2b out_acc", out_acc, 64'sd6);
    chk("b2b out_count", 64'(out_count), 64'd1);
    @(negedge clk);

    // Abort a batch with clear, then run a fresh one
    feed(8'd4, 64'sd3, 1'b0);
    feed(8'd4, 64'sd4, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_product = 64'sd100;
    #1 chk("clear in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    chk("clear out_count", 64'(out_count), 64'd0);
    chk("clear out_acc", out_acc, 64'd0);
    chk("clear out_valid", 64'(out_valid), 64'd0);
    feed(8'd2, 64'sd5, 1'b0);
    feed(8'd2, 64'sd7, 1'b0);
    chk("post-clear out_acc", out_acc, 64'sd12);
    chk("post-clear out_count", 64'(out_count), 64'd2);
    chk("post-clear out_overflow", 64'(out_overflow), 64'd0);
    @(negedge clk);

    // Stall with en low mid-batch
    feed(8'd4, 64'sd3, 1'b0);
    feed(8'd4, 64'sd4, 1'b0);
    en = 1'b0; in_valid = 1'b1; in_product = 64'sd50;
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      chk("stall out_count", 64'(out_count), 64'd2);
      chk("stall out_acc", out_acc, 64'sd7);
    end
    en = 1'b1; in_valid = 1'b0;
    feed(8'd4, 64'sd1, 1'b0);
    feed(8'd4, 64'sd2, 1'b0);
    chk("stall resume out_acc", out_acc, 64'sd10);
    chk("stall resume out_valid", 64'(out_valid), 64'd1);
    @(negedge clk);

    // Asynchronous reset mid-batch
    feed(8'd4, 64'sd3, 1'b0);
    feed(8'd4, 64'sd9, 1'b1);
    in_valid = 1'b1; in_product = 64'sd1;
    #2 reset = 1'b1;
    #1;
    chk("async rst out_acc", out_acc, 64'd0);
    chk("async rst out_count", 64'(out_count), 64'd0);
    chk("async rst out_overflow", 64'(out_overflow), 64'd0);
    chk("async rst in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b0;
    chk("async rst out_valid", 64'(out_valid), 64'd0);

    // Randomized traffic against the batch model
    m_hold = 1'b0; m_active = 1'b0; m_ovf = 1'b0;
    m_len = '0; m_cnt = '0; m_acc = '0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      chk("rnd out_valid", 64'(out_valid), 64'(m_hold));
      if (m_hold) begin
        chk("rnd out_acc", out_acc, m_acc);
        chk("rnd out_count", 64'(out_count), 64'(m_cnt));
        chk("rnd out_overflow", 64'(out_overflow), 64'(m_ovf));
      end
      en          = ($urandom_range(0, 7) != 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      len         = 8'($urandom_range(0, 4));
      in_overflow = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) in_product = {$urandom, $urandom};
      else in_product = int'($urandom_range(0, 2000)) - 1000;
      #1 chk("rnd in_ready", 64'(in_ready), 64'(en & (!m_hold | out_ready)));
      if (en) begin
        if (m_hold && out_ready) m_hold = 1'b0;
        if (in_valid && !m_hold) begin
          if (!m_active) begin
            m_len = (len == 0) ? 8'd1 : len;
            m_acc = in_product; m_cnt = 8'd1; m_ovf = in_overflow;
          end else begin
            model_add(in_product, in_overflow);
          end
          if (m_cnt == m_len) begin
            m_hold = 1'b1; m_active = 1'b0;
          end else begin
            m_active = 1'b1;
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
